// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin sharing of the single register-file write port among NREQ sources.
// Optional register busy scoreboard is built when RF_WB_SCOREBOARD_EN is defined.
module rf_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*SEL_W-1:0]    req_sel,
    input  logic [NREQ*DATA_W-1:0]   req_dat,
    output logic                     rf_wen,
    output logic [SEL_W-1:0]         rf_wsel,
    output logic [DATA_W-1:0]        rf_wdat,
    output logic [ID_W-1:0]          grant_id
`ifdef RF_WB_SCOREBOARD_EN
    ,
    input  logic                     claim_val,
    input  logic [SEL_W-1:0]         claim_sel,
    output logic [31:0]              busy
`endif
);

    logic [SEL_W-1:0]  sel_arr [NREQ];
    logic [DATA_W-1:0] dat_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign sel_arr[i] = req_sel[i*SEL_W +: SEL_W];
        assign dat_arr[i] = req_dat[i*DATA_W +: DATA_W];
    end

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   ptr_nxt;
    logic              xfer;
    logic [SEL_W-1:0]  win_sel;
    logic [DATA_W-1:0] win_dat;

    // Rotating search: the first valid index at or after rr_ptr wins; reset masks all grants.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        req_ready = '0;
        xfer      = 1'b0;
        win_id    = '0;
        win_sel   = '0;
        win_dat   = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NREQ)) begin
                sum = sum - (ID_W+1)'(NREQ);
            end
            idx = sum[ID_W-1:0];
            if (!rst && !xfer && req_valid[idx]) begin
                xfer           = 1'b1;
                win_id         = idx;
                win_sel        = sel_arr[idx];
                win_dat        = dat_arr[idx];
                req_ready[idx] = 1'b1;
            end
        end
    end

    assign ptr_nxt = (win_id == ID_W'(NREQ-1)) ? '0 : win_id + 1'b1;

    // x0 writes still take a grant and advance the pointer, they just never raise rf_wen.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            rf_wen   <= 1'b0;
            rf_wsel  <= '0;
            rf_wdat  <= '0;
            grant_id <= '0;
        end else if (xfer) begin
            rr_ptr   <= ptr_nxt;
            rf_wen   <= (win_sel != '0);
            rf_wsel  <= win_sel;
            rf_wdat  <= win_dat;
            grant_id <= win_id;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

`ifdef RF_WB_SCOREBOARD_EN
    logic [31:0] busy_nxt;

    // Retire first, then claim, so a same-cycle claim of the retiring register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (rf_wen) begin
            busy_nxt[rf_wsel] = 1'b0;
        end
        if (claim_val && (claim_sel != '0)) begin
            busy_nxt[claim_sel] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios followed by random traffic, all
// checked against a round-robin reference model kept here.
module tb_rf_write_arbiter;

    localparam int NREQ   = 3;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*SEL_W-1:0]  req_sel;
    logic [NREQ*DATA_W-1:0] req_dat;
    logic                   rf_wen;
    logic [SEL_W-1:0]       rf_wsel;
    logic [DATA_W-1:0]      rf_wdat;
    logic [1:0]             grant_id;
`ifdef RF_WB_SCOREBOARD_EN
    logic                   claim_val;
    logic [SEL_W-1:0]       claim_sel;
    logic [31:0]            busy;
`endif

    always #5 clk = ~clk;

    rf_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_dat   (req_dat),
        .rf_wen    (rf_wen),
        .rf_wsel   (rf_wsel),
        .rf_wdat   (rf_wdat),
        .grant_id  (grant_id)
`ifdef RF_WB_SCOREBOARD_EN
        ,
        .claim_val (claim_val),
        .claim_sel (claim_sel),
        .busy      (busy)
`endif
    );

    // reference model state
    int          m_ptr;
    logic        m_wen;
    logic [4:0]  m_wsel;
    logic [31:0] m_wdat;
    int          m_gid;
    logic [31:0] m_busy;

    int checks = 0;
    int errors = 0;

    logic [4:0]  d_sel [NREQ];
    logic [31:0] d_dat [NREQ];

    always_comb begin
        req_sel = '0;
        req_dat = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_sel[i*SEL_W +: SEL_W]   = d_sel[i];
            req_dat[i*DATA_W +: DATA_W] = d_dat[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] s, input logic [31:0] d);
        req_valid[i] = v;
        d_sel[i]     = s;
        d_dat[i]     = d;
    endtask

    // Who should win: walk the requesters in circular order starting at the model pointer.
    function automatic int model_grant();
        if (rst) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    // One clock: check ready before the edge, advance the model at the edge, check outputs after.
    task automatic cycle(output int g);
        logic [31:0] exp_ready;
        #1;
        g = model_grant();
        exp_ready = (g >= 0) ? (32'd1 << g) : 32'd0;
        chk("req_ready", {29'd0, req_ready}, exp_ready);
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_wen = 1'b0; m_wsel = '0; m_wdat = '0; m_gid = 0; m_busy = '0;
        end else begin
`ifdef RF_WB_SCOREBOARD_EN
            if (m_wen) m_busy[m_wsel] = 1'b0;
            if (claim_val && claim_sel != 5'd0) m_busy[claim_sel] = 1'b1;
`endif
            if (g >= 0) begin
                m_wsel = d_sel[g];
                m_wdat = d_dat[g];
                m_gid  = g;
                m_wen  = (d_sel[g] != 5'd0);
                m_ptr  = (g + 1) % NREQ;
            end else begin
                m_wen = 1'b0;
            end
        end
        #1;
        chk("rf_wen",   {31'd0, rf_wen},   {31'd0, m_wen});
        chk("rf_wsel",  {27'd0, rf_wsel},  {27'd0, m_wsel});
        chk("rf_wdat",  rf_wdat,           m_wdat);
        chk("grant_id", {30'd0, grant_id}, 32'(m_gid));
`ifdef RF_WB_SCOREBOARD_EN
        chk("busy",     busy,              m_busy);
`endif
    endtask

    initial begin
        int g;
        rst = 1'b1;
        req_valid = '0;
`ifdef RF_WB_SCOREBOARD_EN
        claim_val = 1'b0;
        claim_sel = '0;
`endif
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'hA000_0000 + i);

        // reset held with everyone requesting
        cycle(g);
        cycle(g);
        chk("t1_rst_wen", {31'd0, rf_wen}, 32'd0);
        chk("t1_rst_ready", {29'd0, req_ready}, 32'd0);

        // release: grants 0,1,2,0,1,2; requesters drop in the last round once served
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle(g);
            chk("t3_gid", {30'd0, grant_id}, 32'(k % 3));
            chk("t3_wen", {31'd0, rf_wen}, 32'd1);
            if (k >= 3) req_valid[k % 3] = 1'b0;
        end

        // single requester 1
        set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
        cycle(g);
        req_valid[1] = 1'b0;
        chk("t2_wen",  {31'd0, rf_wen},   32'd1);
        chk("t2_wsel", {27'd0, rf_wsel},  32'd7);
        chk("t2_wdat", rf_wdat,           32'hDEADBEEF);
        chk("t2_gid",  {30'd0, grant_id}, 32'd1);

        // requester 2 writes x0: accepted, no rf_wen, pointer wraps to 0
        set_req(2, 1'b1, 5'd0, 32'h0000_0055);
        cycle(g);
        req_valid[2] = 1'b0;
        chk("t4_wen", {31'd0, rf_wen},   32'd0);
        chk("t4_gid", {30'd0, grant_id}, 32'd2);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(10 + i), 32'hB000_0000 + i);
        for (int k = 0; k < 3; k++) begin
            cycle(g);
            chk("t4_wrap_gid", {30'd0, grant_id}, 32'(k));
            req_valid[k] = 1'b0;
        end

        // reset right after a transfer from requester 1 drops the pointer back to 0
        set_req(1, 1'b1, 5'd9, 32'hC0DE_0001);
        cycle(g);
        req_valid[1] = 1'b0;
        chk("t5_pre_wen", {31'd0, rf_wen}, 32'd1);
        rst = 1'b1;
        set_req(1, 1'b1, 5'd11, 32'hC0DE_0002);
        set_req(2, 1'b1, 5'd12, 32'hC0DE_0003);
        cycle(g);
        chk("t5_rst_wen", {31'd0, rf_wen}, 32'd0);
        rst = 1'b0;
        cycle(g);
        req_valid[1] = 1'b0;
        chk("t5_ptr_gid", {30'd0, grant_id}, 32'd1);
        cycle(g);
        req_valid[2] = 1'b0;

`ifdef RF_WB_SCOREBOARD_EN
        // claim x5, retire with a simultaneous re-claim, then retire for real
        claim_val = 1'b1; claim_sel = 5'd5;
        cycle(g);
        claim_val = 1'b0;
        chk("t6_claim", {31'd0, busy[5]}, 32'd1);
        set_req(0, 1'b1, 5'd5, 32'h5555_0001);
        cycle(g);
        req_valid[0] = 1'b0;
        claim_val = 1'b1; claim_sel = 5'd5;
        cycle(g);
        claim_val = 1'b0;
        chk("t6_claim_wins", {31'd0, busy[5]}, 32'd1);
        set_req(0, 1'b1, 5'd5, 32'h5555_0002);
        cycle(g);
        req_valid[0] = 1'b0;
        chk("t6_wen", {31'd0, rf_wen}, 32'd1);
        cycle(g);
        chk("t6_retire", {31'd0, busy[5]}, 32'd0);
`endif

        // random traffic honouring the hold-until-ready rule
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 55) begin
                    logic [4:0] s;
                    s = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    set_req(i, 1'b1, s, $urandom);
                end
            end
`ifdef RF_WB_SCOREBOARD_EN
            claim_val = ($urandom_range(0, 99) < 40);
            claim_sel = 5'($urandom_range(0, 31));
`endif
            rst = ($urandom_range(0, 99) < 2);
            cycle(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
